// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-access stage.
// The wait counter must be able to count up to TIMEOUT.
package mem_stage_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int REG_W_DEF   = 5;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/dmem_access_fsm.sv
// Data-memory handshake controller: tracks an outstanding access,
// generates the request and the upstream stall, and aborts on timeout.
module dmem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_op,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic mem_stall,
  output logic abort
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  mem_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             req_s, abort_s;

  // State and wait-counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state, counter and raw request/abort decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    req_s       = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      IDLE: begin
        req_s = mem_op;
        if (mem_op && !dmem_ack) begin
          state_nxt_s = WAIT;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        req_s = 1'b1;
        if (dmem_ack) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == CNT_MAX) begin
          abort_s     = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Everything seen outside is silenced while reset is held
  assign dmem_req  = rst & req_s;
  assign abort     = rst & abort_s;
  assign mem_stall = rst & mem_op & ~dmem_ack & ~abort_s;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register: branch resolution, data-memory
// access with stall/timeout, and the registered write-back bundle.
module mem_wb_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_MEM_valid,
  input  logic [DATA_W-1:0] EX_MEM_adder_result,
  input  logic              EX_MEM_zero,
  input  logic [DATA_W-1:0] EX_MEM_alu_result,
  input  logic [DATA_W-1:0] EX_MEM_read2_data,
  input  logic [REG_W-1:0]  EX_MEM_RD,
  input  logic              EX_MEM_RegWrite,
  input  logic              EX_MEM_MemtoReg,
  input  logic              EX_MEM_MemWrite,
  input  logic              EX_MEM_MemRead,
  input  logic              EX_MEM_Branch,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              MEM_WB_valid,
  output logic              MEM_WB_RegWrite,
  output logic              MEM_WB_MemtoReg,
  output logic [DATA_W-1:0] MEM_WB_read_data,
  output logic [DATA_W-1:0] MEM_WB_alu_result,
  output logic [REG_W-1:0]  MEM_WB_RD,
  output logic              mem_err
);

  logic mem_op_s, is_load_s, abort_s;

  // A set MemWrite wins over MemRead, so such an op is a store
  assign mem_op_s  = EX_MEM_valid & (EX_MEM_MemRead | EX_MEM_MemWrite);
  assign is_load_s = mem_op_s & EX_MEM_MemRead & ~EX_MEM_MemWrite;

  assign pc_src        = rst & EX_MEM_valid & EX_MEM_Branch & EX_MEM_zero;
  assign branch_target = EX_MEM_adder_result;
  assign dmem_we       = dmem_req & EX_MEM_MemWrite;
  assign dmem_addr     = EX_MEM_alu_result;
  assign dmem_wdata    = EX_MEM_read2_data;

  dmem_access_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .mem_op   (mem_op_s),
    .dmem_ack (dmem_ack),
    .dmem_req (dmem_req),
    .mem_stall(mem_stall),
    .abort    (abort_s)
  );

  // MEM/WB register: retire, or insert a bubble on stall/abort
  always_ff @(posedge clk) begin
    if (!rst) begin
      MEM_WB_valid      <= 1'b0;
      MEM_WB_RegWrite   <= 1'b0;
      MEM_WB_MemtoReg   <= 1'b0;
      MEM_WB_read_data  <= {DATA_W{1'b0}};
      MEM_WB_alu_result <= {DATA_W{1'b0}};
      MEM_WB_RD         <= {REG_W{1'b0}};
    end else if (mem_stall || abort_s) begin
      MEM_WB_valid    <= 1'b0;
      MEM_WB_RegWrite <= 1'b0;
    end else begin
      MEM_WB_valid      <= EX_MEM_valid;
      MEM_WB_RegWrite   <= EX_MEM_RegWrite;
      MEM_WB_MemtoReg   <= EX_MEM_MemtoReg;
      MEM_WB_alu_result <= EX_MEM_alu_result;
      MEM_WB_RD         <= EX_MEM_RD;
      if (is_load_s) begin
        MEM_WB_read_data <= dmem_rdata;
      end else begin
        MEM_WB_read_data <= MEM_WB_read_data;
      end
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_err <= 1'b0;
    end else if (abort_s) begin
      mem_err <= 1'b1;
    end else begin
      mem_err <= mem_err;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases then random
// instructions with random memory latency, against a timeline model.
module tb_mem_wb_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TO = 4;

  logic          clk, rst;
  logic          ex_valid, ex_zero, ex_rw, ex_m2r, ex_mw, ex_mr, ex_br;
  logic [DW-1:0] ex_tgt, ex_alu, ex_wd;
  logic [RW-1:0] ex_rd;
  logic          pc_src, mem_stall, dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0] branch_target, dmem_addr, dmem_wdata, dmem_rdata;
  logic          wb_valid, wb_rw, wb_m2r, mem_err;
  logic [DW-1:0] wb_rdata, wb_alu;
  logic [RW-1:0] wb_rd;

  // expected MEM/WB contents
  logic          m_valid, m_rw, m_m2r, m_err;
  logic [DW-1:0] m_rdata, m_alu;
  logic [RW-1:0] m_rd;

  int n_cmp = 0;
  int n_bad = 0;

  mem_wb_stage #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .EX_MEM_valid(ex_valid), .EX_MEM_adder_result(ex_tgt), .EX_MEM_zero(ex_zero),
    .EX_MEM_alu_result(ex_alu), .EX_MEM_read2_data(ex_wd), .EX_MEM_RD(ex_rd),
    .EX_MEM_RegWrite(ex_rw), .EX_MEM_MemtoReg(ex_m2r), .EX_MEM_MemWrite(ex_mw),
    .EX_MEM_MemRead(ex_mr), .EX_MEM_Branch(ex_br),
    .pc_src(pc_src), .branch_target(branch_target), .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .MEM_WB_valid(wb_valid), .MEM_WB_RegWrite(wb_rw), .MEM_WB_MemtoReg(wb_m2r),
    .MEM_WB_read_data(wb_rdata), .MEM_WB_alu_result(wb_alu), .MEM_WB_RD(wb_rd),
    .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string where);
    check_val({where, ".valid"},    32'(wb_valid), 32'(m_valid));
    check_val({where, ".regwrite"}, 32'(wb_rw),    32'(m_rw));
    check_val({where, ".memtoreg"}, 32'(wb_m2r),   32'(m_m2r));
    check_val({where, ".rdata"},    wb_rdata,      m_rdata);
    check_val({where, ".alu"},      wb_alu,        m_alu);
    check_val({where, ".rd"},       32'(wb_rd),    32'(m_rd));
    check_val({where, ".err"},      32'(mem_err),  32'(m_err));
  endtask

  task automatic zero_inputs();
    ex_valid = 1'b0; ex_zero = 1'b0; ex_rw = 1'b0; ex_m2r = 1'b0;
    ex_mw = 1'b0; ex_mr = 1'b0; ex_br = 1'b0; ex_tgt = 32'd0;
    ex_alu = 32'd0; ex_wd = 32'd0; ex_rd = 5'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_rw = 1'b0; m_m2r = 1'b0; m_err = 1'b0;
    m_rdata = 32'd0; m_alu = 32'd0; m_rd = 5'd0;
  endtask

  // One instruction held in EX/MEM; memory acks 'lat' cycles after the first request
  task automatic run_instr(input string tag, input logic v, br, z, rw, m2r, mw, mr,
                           input logic [31:0] tgt, alu, wd, input logic [4:0] rd,
                           input int lat, input bit use_fix, input logic [31:0] fix_rdata);
    bit            mem_op, is_load, timed_out;
    int            last;
    logic [31:0]   cap;
    mem_op    = v && (mr || mw);
    is_load   = mem_op && mr && !mw;
    timed_out = mem_op && (lat > TO);
    last      = !mem_op ? 0 : (lat < TO ? lat : TO);
    cap       = 32'd0;
    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      ex_valid = v; ex_br = br; ex_zero = z; ex_rw = rw; ex_m2r = m2r; ex_mw = mw; ex_mr = mr;
      ex_tgt = tgt; ex_alu = alu; ex_wd = wd; ex_rd = rd;
      dmem_ack   = mem_op ? (j == lat) : 1'($urandom_range(0, 1));
      dmem_rdata = use_fix ? fix_rdata : $urandom;
      cap = dmem_rdata;
      #1;
      check_val({tag, ".pc_src"}, 32'(pc_src), 32'(v && br && z));
      check_val({tag, ".target"}, branch_target, tgt);
      check_val({tag, ".req"},    32'(dmem_req), 32'(mem_op));
      check_val({tag, ".stall"},  32'(mem_stall), 32'(mem_op && (j < last)));
      if (mem_op) check_val({tag, ".we"}, 32'(dmem_we), 32'(mw));
      check_val({tag, ".addr"},  dmem_addr, alu);
      check_val({tag, ".wdata"}, dmem_wdata, wd);
      @(posedge clk);
      #1;
      if (j < last || timed_out) begin
        m_valid = 1'b0;
        m_rw    = 1'b0;
        if (j == last) m_err = 1'b1;
      end else begin
        m_valid = v; m_rw = rw; m_m2r = m2r; m_alu = alu; m_rd = rd;
        if (is_load) m_rdata = cap;
      end
      check_regs(tag);
    end
  endtask

  initial begin
    rst = 1'b0;
    zero_inputs();
    model_reset();
    // outputs must stay quiet under reset even with a live branch/load presented
    ex_valid = 1'b1; ex_br = 1'b1; ex_zero = 1'b1; ex_mr = 1'b1; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst.req",    32'(dmem_req),  32'd0);
    check_val("rst.stall",  32'(mem_stall), 32'd0);
    check_val("rst.pc_src", 32'(pc_src),    32'd0);
    @(posedge clk);
    #1;
    check_regs("rst");
    @(negedge clk);
    zero_inputs();
    rst = 1'b1;

    run_instr("ld0",   1, 0, 0, 1, 1, 0, 1, 32'h0, 32'h100, 32'h0,   5'd7, 0, 1, 32'hDEADBEEF);
    check_val("ld0.data", wb_rdata, 32'hDEADBEEF);
    run_instr("st3",   1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h40,  32'h1234, 5'd3, 3, 0, 32'h0);
    run_instr("br_t",  1, 1, 1, 0, 0, 0, 0, 32'h200, 32'h0, 32'h0,   5'd0, 0, 0, 32'h0);
    run_instr("br_nt", 1, 1, 0, 0, 0, 0, 0, 32'h200, 32'h0, 32'h0,   5'd0, 0, 0, 32'h0);
    run_instr("tmo",   1, 0, 0, 1, 1, 0, 1, 32'h0, 32'h80,  32'h0,   5'd9, 9, 0, 32'h0);
    check_val("tmo.err", 32'(mem_err), 32'd1);
    run_instr("bub",   0, 0, 0, 1, 1, 0, 1, 32'h0, 32'h44,  32'h0,   5'd2, 0, 0, 32'h0);
    run_instr("both",  1, 0, 0, 1, 0, 1, 1, 32'h0, 32'h60,  32'h55,  5'd4, 1, 0, 32'h0);

    // reset while a load is waiting; a late ack must be ignored
    @(negedge clk);
    ex_valid = 1'b1; ex_mr = 1'b1; ex_mw = 1'b0; ex_rw = 1'b1; ex_alu = 32'h300; dmem_ack = 1'b0;
    @(negedge clk);
    #1;
    check_val("rstw.req_before", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    dmem_ack = 1'b1;
    #1;
    check_val("rstw.req",   32'(dmem_req),  32'd0);
    check_val("rstw.stall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    model_reset();
    check_regs("rstw");
    @(negedge clk);
    zero_inputs();
    rst = 1'b1;

    for (int i = 0; i < 300; i++) begin
      logic v, br, z, rw, m2r, mw, mr;
      v   = ($urandom_range(0, 7) != 0);
      br  = 1'($urandom_range(0, 3) == 0);
      z   = 1'($urandom_range(0, 1));
      rw  = 1'($urandom_range(0, 1));
      m2r = 1'($urandom_range(0, 1));
      mw  = br ? 1'b0 : 1'($urandom_range(0, 1));
      mr  = br ? 1'b0 : 1'($urandom_range(0, 1));
      run_instr("rnd", v, br, z, rw, m2r, mw, mr, $urandom, $urandom, $urandom,
                5'($urandom_range(0, 31)), int'($urandom_range(0, TO + 2)), 0, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register for the 5-stage pipelined CPU. It consumes the EX/MEM register contents, resolves branches (PCSrc), and performs loads/stores over a variable-latency data-memory handshake, stalling the upstream stages while an access is outstanding. It then registers the write-back bundle (read data, ALU result, RD, WB controls) for the WB stage, and flags a sticky error on memory timeout.

## Interface
Parameters:
- DATA_W, 32, data/address width
- REG_W, 5, register-index width
- TIMEOUT, 255, max wait cycles for dmem_ack before abort (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-low (rst=0 resets on clk rising edge)
- EX_MEM_valid  in  1  EX/MEM holds a real instruction (0 = bubble)
- EX_MEM_adder_result  in  DATA_W  branch target
- EX_MEM_zero  in  1  ALU zero flag
- EX_MEM_alu_result  in  DATA_W  memory address / ALU result
- EX_MEM_read2_data  in  DATA_W  store data
- EX_MEM_RD  in  REG_W  destination register
- EX_MEM_RegWrite, EX_MEM_MemtoReg, EX_MEM_MemWrite, EX_MEM_MemRead, EX_MEM_Branch  in  1 each  control bits
- pc_src  out  1  take branch: combinational, = valid & Branch & zero
- branch_target  out  DATA_W  = EX_MEM_adder_result
- mem_stall  out  1  combinational; freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- dmem_req  out  1  access request (combinational)
- dmem_we  out  1  1 = store
- dmem_addr, dmem_wdata  out  DATA_W  = alu_result, read2_data
- dmem_ack  in  1  access complete this cycle
- dmem_rdata  in  DATA_W  load data, valid when dmem_ack=1
- MEM_WB_valid, MEM_WB_RegWrite, MEM_WB_MemtoReg  out  1 each  registered
- MEM_WB_read_data, MEM_WB_alu_result  out  DATA_W  registered
- MEM_WB_RD  out  REG_W  registered
- mem_err  out  1  sticky timeout flag, registered

## Operation
- mem_op = EX_MEM_valid & (MemRead | MemWrite); MemRead & MemWrite both set is treated as a store.
- FSM states: IDLE, WAIT.
  - IDLE: dmem_req = mem_op. If mem_op & dmem_ack: retire. If mem_op & !ack: go WAIT, wait counter reset to 1. If !mem_op: retire (ALU op or bubble).
  - WAIT: dmem_req = 1, address/data/we held stable (EX/MEM is frozen). If ack: retire, go IDLE. Else if counter == TIMEOUT: abort → mem_err<=1, retire as squash, go IDLE. Else counter++.
- mem_stall = mem_op & !dmem_ack & !abort.
- Retire (on edge): MEM_WB_* <= EX_MEM_* fields; MEM_WB_read_data <= dmem_rdata for loads, else holds previous value; MEM_WB_valid <= EX_MEM_valid.
- Stall cycle: MEM_WB_valid, MEM_WB_RegWrite <= 0 (bubble inserted into WB); other MEM_WB data regs hold.
- Squash (abort): same as bubble; the faulting instruction never writes back.
- pc_src is independent of FSM; branches carry no memory op and never stall.
- mem_err clears only on reset.

## Timing
- Reset: all MEM_WB_* = 0, mem_err = 0, state IDLE, counter 0; dmem_req, pc_src, and mem_stall forced to 0 while rst=0.
- Zero-wait access (ack in same cycle as req): 0 stall cycles; MEM_WB updated at next edge.
- Ack k cycles after first req: mem_stall high for k cycles; retire on the ack-cycle edge.
- Timeout: req high for TIMEOUT+1 cycles; stall drops in the abort cycle.
- Reset asserted in WAIT: next cycle req = 0, state IDLE; any late ack is ignored.
- Back-to-back memory ops: a new req may start in the cycle after retirement; no dead cycle.

## Structure
- Package mem_stage_pkg: state enum {IDLE, WAIT}, default widths, counter width $clog2(TIMEOUT+1).
- Sub-module dmem_access_fsm: state, counter, dmem_req/stall/abort generation. The top level holds the MEM/WB register and branch logic.

## Test plan
- Reset mid-WAIT: rst=0 while stalled → next cycle dmem_req=0, all MEM_WB_*=0, mem_err=0.
- Load, zero-wait: MemRead, alu_result=0x100, rdata=0xDEADBEEF, ack same cycle, RD=7 → next cycle MEM_WB_read_data=0xDEADBEEF, RD=7, RegWrite=1, no stall.
- Store, 3-cycle latency: MemWrite, addr 0x40, wdata 0x1234 → req/we/addr/wdata stable 4 cycles, mem_stall=1 for 3, MEM_WB_valid=0 during stall, =1 after.
- Branch: Branch=1, zero=1, adder_result=0x200 → pc_src=1, branch_target=0x200 same cycle; zero=0 → pc_src=0.
- Timeout with TIMEOUT=4 and no ack → req high 5 cycles, then mem_err=1 sticky, MEM_WB_RegWrite=0, stall released.
- Bubble (EX_MEM_valid=0 with MemRead=1) → no req, no stall, MEM_WB_valid=0.
